pc_sequencer: RTL and testbench

- Fetch/execute controller that replaces the free-running program counter in `computer`.
- Owns the 4-bit PC and sequences each instruction as FETCH (wait on instruction-memory ready) then EXEC (one cycle, register loads enabled).
- Latches ALU zero/negative flags and implements JMP/JEQ/JNE/HLT plus run/single-step control.
- `exec_en` gates the LA/LB loads produced by `control_unit`.

---
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Fetch/execute controller for the small `computer` datapath. It owns the
//   4-bit program counter and runs each instruction as FETCH (wait for the
//   instruction memory) followed by a single EXEC cycle. During that EXEC
//   cycle the register loads are enabled and jumps or halt are resolved.
//   ALU zero/negative flags are latched for the conditional jumps.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   run        in   level, execute continuously
//   step       in   execute one instruction when idle (sampled in IDLE only)
//   im[8:0]    in   instruction word at address pc
//   mem_ready  in   instruction memory holds valid data for pc
//   alu_out    in   ALU result for the instruction in EXEC
//   pc[3:0]    out  program counter / instruction-memory address
//   fetch_req  out  high while in FETCH
//   exec_en    out  high in EXEC for non-control instructions (gates LA/LB)
//   halted     out  high in HALT
//   z_flag     out  latched zero flag
//   n_flag     out  latched negative flag
//   icount     out  retired-instruction count, saturating at 255
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [4:0] OP_JMP = 5'b11100,
  parameter logic [4:0] OP_JEQ = 5'b11101,
  parameter logic [4:0] OP_JNE = 5'b11110,
  parameter logic [4:0] OP_HLT = 5'b11111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic [8:0] im,
  input  logic       mem_ready,
  input  logic [7:0] alu_out,
  output logic [3:0] pc,
  output logic       fetch_req,
  output logic       exec_en,
  output logic       halted,
  output logic       z_flag,
  output logic       n_flag,
  output logic [7:0] icount
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0] state;
  logic       single_shot;
  logic [4:0] opcode;
  logic [3:0] target;
  logic [3:0] pc_inc;
  logic       is_ctrl;

  assign opcode  = im[8:4];
  assign target  = im[3:0];
  assign pc_inc  = pc + 4'd1;   // 4-bit add wraps 15 -> 0
  assign is_ctrl = (opcode == OP_JMP) || (opcode == OP_JEQ) ||
                   (opcode == OP_JNE) || (opcode == OP_HLT);

  // Outputs are pure state decodes; run/step never reach them directly.
  assign fetch_req = (state == S_FETCH);
  assign exec_en   = (state == S_EXEC) && !is_ctrl;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      single_shot <= 1'b0;
      pc          <= 4'd0;
      z_flag      <= 1'b0;
      n_flag      <= 1'b0;
      icount      <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // run wins over step, so single-shot is only set for a lone step
          if (run) begin
            state       <= S_FETCH;
            single_shot <= 1'b0;
          end else if (step) begin
            state       <= S_FETCH;
            single_shot <= 1'b1;
          end
        end

        S_FETCH: begin
          if (mem_ready) state <= S_EXEC;
        end

        S_EXEC: begin
          if (icount != 8'hFF) icount <= icount + 8'd1;

          // Jumps test the flags latched by earlier instructions and leave
          // them untouched; only ALU instructions refresh Z/N.
          if (opcode == OP_JMP) begin
            pc <= target;
          end else if (opcode == OP_JEQ) begin
            pc <= z_flag ? target : pc_inc;
          end else if (opcode == OP_JNE) begin
            pc <= !z_flag ? target : pc_inc;
          end else if (opcode != OP_HLT) begin
            pc     <= pc_inc;
            z_flag <= (alu_out == 8'h00);
            n_flag <= alu_out[7];
          end

          if (opcode == OP_HLT) begin
            state <= S_HALT;
          end else if (single_shot) begin
            state       <= S_IDLE;
            single_shot <= 1'b0;
          end else if (run) begin
            state <= S_FETCH;
          end else begin
            state <= S_IDLE;
          end
        end

        default: begin
          // HALT is absorbing; only reset leaves it
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       step;
  logic [8:0] im;
  logic       mem_ready;
  logic [7:0] alu_out;
  logic [3:0] pc;
  logic       fetch_req;
  logic       exec_en;
  logic       halted;
  logic       z_flag;
  logic       n_flag;
  logic [7:0] icount;

  int total = 0;
  int bad   = 0;

  // Instruction memory and the ALU result each address produces
  logic [8:0] prog [16];
  logic [7:0] aluv [16];

  localparam logic [4:0] JMP = 5'b11100;
  localparam logic [4:0] JEQ = 5'b11101;
  localparam logic [4:0] JNE = 5'b11110;
  localparam logic [4:0] HLT = 5'b11111;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .im        (im),
    .mem_ready (mem_ready),
    .alu_out   (alu_out),
    .pc        (pc),
    .fetch_req (fetch_req),
    .exec_en   (exec_en),
    .halted    (halted),
    .z_flag    (z_flag),
    .n_flag    (n_flag),
    .icount    (icount)
  );

  // Memory and ALU respond to whatever address the sequencer presents
  always_comb begin
    im      = prog[pc];
    alu_out = aluv[pc];
  end

  // ------------------------------------------------------------------
  // Reference model: what the machine must be doing, phase by phase,
  // with instruction semantics expressed as plain integer arithmetic.
  // ------------------------------------------------------------------
  typedef enum {M_IDLE, M_FETCH, M_EXEC, M_HALT} mph_t;
  mph_t ph;
  int   m_pc;
  bit   m_z, m_n, m_ss, m_valid = 0;
  int   m_cnt;

  function automatic bit is_ctrl(input logic [8:0] w);
    return w[8:5] == 4'b1111 - 4'b0001 || w[8:5] == 4'b1111;
  endfunction

  task automatic retire();
    logic [8:0] w;
    int tgt;
    w   = prog[m_pc];
    tgt = int'(w[3:0]);
    m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    case (w[8:4])
      JMP:     m_pc = tgt;
      JEQ:     m_pc = m_z ? tgt : (m_pc + 1) % 16;
      JNE:     m_pc = !m_z ? tgt : (m_pc + 1) % 16;
      HLT:     ;
      default: begin
        m_z  = (aluv[m_pc] == 0);
        m_n  = aluv[m_pc] >= 128;
        m_pc = (m_pc + 1) % 16;
      end
    endcase
    if (w[8:4] == HLT)  ph = M_HALT;
    else if (m_ss)      begin ph = M_IDLE; m_ss = 0; end
    else if (run)       ph = M_FETCH;
    else                ph = M_IDLE;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = M_IDLE; m_pc = 0; m_z = 0; m_n = 0; m_cnt = 0; m_ss = 0;
      m_valid = 1;
    end else begin
      case (ph)
        M_IDLE:  if (run) begin ph = M_FETCH; m_ss = 0; end
                 else if (step) begin ph = M_FETCH; m_ss = 1; end
        M_FETCH: if (mem_ready) ph = M_EXEC;
        M_EXEC:  retire();
        M_HALT:  ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc",        {4'd0, pc},        8'(m_pc));
      chk("fetch_req", {7'd0, fetch_req}, {7'd0, ph == M_FETCH});
      chk("exec_en",   {7'd0, exec_en},   {7'd0, ph == M_EXEC && !is_ctrl(prog[m_pc])});
      chk("halted",    {7'd0, halted},    {7'd0, ph == M_HALT});
      chk("z_flag",    {7'd0, z_flag},    {7'd0, m_z});
      chk("n_flag",    {7'd0, n_flag},    {7'd0, m_n});
      chk("icount",    icount,            8'(m_cnt));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      prog[i] = 9'(i);      // plain ALU op
      aluv[i] = 8'h01;
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; mem_ready = 1'b1;
    clear_prog();
    cyc(2);
    rst_n = 1'b1;

    // Idle after reset
    cyc(10);
    chk("idle_pc", {4'd0, pc}, 8'd0);
    chk("idle_fetch", {7'd0, fetch_req}, 8'd0);
    chk("idle_exec", {7'd0, exec_en}, 8'd0);
    chk("idle_icount", icount, 8'd0);

    // Three ALU ops then JMP 0
    prog[3] = {JMP, 4'd0};
    run = 1'b1;
    cyc(3);
    chk("seq_pc1", {4'd0, pc}, 8'd1);
    cyc(6);
    chk("seq_pc0", {4'd0, pc}, 8'd0);
    chk("seq_icount", icount, 8'd4);
    run = 1'b0;
    cyc(3);
    chk("seq_stop_pc", {4'd0, pc}, 8'd1);

    // Flags and conditional jumps
    do_reset();
    clear_prog();
    aluv[0]  = 8'h00;
    prog[1]  = {JEQ, 4'd9};
    aluv[9]  = 8'h80;
    prog[10] = {JEQ, 4'd9};
    prog[11] = {JNE, 4'd9};
    run = 1'b1;
    cyc(3);
    chk("jeq_z1", {7'd0, z_flag}, 8'd1);
    cyc(2);
    chk("jeq_taken_pc", {4'd0, pc}, 8'd9);
    cyc(2);
    chk("neg_n1", {7'd0, n_flag}, 8'd1);
    chk("neg_z0", {7'd0, z_flag}, 8'd0);
    cyc(2);
    chk("jeq_fall_pc", {4'd0, pc}, 8'd11);
    cyc(2);
    chk("jne_taken_pc", {4'd0, pc}, 8'd9);
    run = 1'b0;
    cyc(3);

    // Single step with a slow memory
    do_reset();
    clear_prog();
    step = 1'b1; mem_ready = 1'b0;
    cyc(1);
    step = 1'b0;
    cyc(3);
    chk("step_fetch_wait", {7'd0, fetch_req}, 8'd1);
    chk("step_pc_hold", {4'd0, pc}, 8'd0);
    mem_ready = 1'b1;
    cyc(1);
    chk("step_exec", {7'd0, exec_en}, 8'd1);
    cyc(1);
    chk("step_pc", {4'd0, pc}, 8'd1);
    chk("step_icount", icount, 8'd1);
    cyc(3);
    chk("step_idle_pc", {4'd0, pc}, 8'd1);
    // step held high: one instruction per 3 cycles
    step = 1'b1;
    cyc(6);
    step = 1'b0;
    chk("step_held_pc", {4'd0, pc}, 8'd3);
    chk("step_held_icount", icount, 8'd3);
    // run and step together act as run alone
    run = 1'b1; step = 1'b1;
    cyc(4);
    run = 1'b0; step = 1'b0;
    cyc(4);

    // Halt at address 5
    do_reset();
    clear_prog();
    prog[5] = {HLT, 4'd0};
    run = 1'b1;
    cyc(14);
    chk("hlt_halted", {7'd0, halted}, 8'd1);
    chk("hlt_pc", {4'd0, pc}, 8'd5);
    chk("hlt_icount", icount, 8'd6);
    for (int i = 0; i < 6; i++) begin
      run = i[0]; step = i[1];
      cyc(1);
    end
    chk("hlt_hold_pc", {4'd0, pc}, 8'd5);
    chk("hlt_hold_icount", icount, 8'd6);
    do_reset();
    #1;
    chk("hlt_rst_halted", {7'd0, halted}, 8'd0);
    chk("hlt_rst_pc", {4'd0, pc}, 8'd0);
    cyc(2);

    // Long loop: wrap via JMP, icount saturation, reset mid-FETCH
    clear_prog();
    prog[15] = {JMP, 4'd0};
    aluv[11] = 8'h90;
    run = 1'b1;
    cyc(601);
    chk("loop_fetch", {7'd0, fetch_req}, 8'd1);
    chk("loop_pc", {4'd0, pc}, 8'd12);
    chk("loop_sat", icount, 8'd255);
    chk("loop_n", {7'd0, n_flag}, 8'd1);
    rst_n = 1'b0; run = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("midrst_pc", {4'd0, pc}, 8'd0);
    chk("midrst_fetch", {7'd0, fetch_req}, 8'd0);
    chk("midrst_n", {7'd0, n_flag}, 8'd0);
    chk("midrst_icount", icount, 8'd0);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
